// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel-1 (write) types used by the GRN DSM writer.
// Encodings follow the CCI-P request/response codes for the fields carried here.
package ccip_if_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef t_ccip_clAddr t_hc_address;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

// File: rtl/grn_pkg.sv
// GRN accelerator shared types: DSM status-line layout and DSM writer FSM states.
package grn_pkg;

  localparam logic [15:0] GRN_DSM_MDATA = 16'hD5A0;
  localparam logic [63:0] GRN_DSM_FLAG  = 64'h1;

  typedef struct packed {
    logic [319:0] rsvd;
    logic [31:0]  seq;
    logic [31:0]  status;
    logic [63:0]  cycles;
    logic [63:0]  flag;
  } t_grn_dsm_line;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } t_grn_dsm_state;

  function automatic t_grn_dsm_line grn_dsm_make_line(
    input logic [63:0] cycles,
    input logic [31:0] status,
    input logic [31:0] seq
  );
    t_grn_dsm_line l;
    l        = '0;
    l.flag   = GRN_DSM_FLAG;
    l.cycles = cycles;
    l.status = status;
    l.seq    = seq;
    return l;
  endfunction

endpackage

// File: rtl/grn_dsm_writer.sv
// Writes one 64-byte DSM status line to host memory per job completion and
// tracks the CCI-P write response, with a one-deep pending slot for early dones.
module grn_dsm_writer
  import ccip_if_pkg::*, grn_pkg::*;
#(
  parameter logic [15:0] MDATA_TAG   = GRN_DSM_MDATA,
  parameter int          RSP_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  t_hc_address    hc_dsm_base,
  input  logic           start,
  input  logic           done,
  input  logic [31:0]    status_code,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx c1Rx,
  output t_if_ccip_c1_Tx c1Tx,
  output logic           dsm_busy,
  output logic           dsm_done,
  output logic           dsm_error
);

  localparam int TIMER_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RSP_TIMEOUT - 1);

  logic [63:0]        cyc_q;
  logic               run_q;
  logic               start_defer_q;

  t_grn_dsm_state     state_q;
  t_grn_dsm_line      line_q;
  t_hc_address        addr_q;
  logic [31:0]        seq_q;
  logic [TIMER_W-1:0] timer_q;

  logic               pend_valid_q;
  logic [31:0]        pend_status_q;
  logic [63:0]        pend_cyc_q;
  t_hc_address        pend_base_q;

  logic rsp_match;
  logic pend_take;
  logic pend_fill;
  logic timeout;

  assign rsp_match = c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE) &&
                     (c1Rx.hdr.mdata == MDATA_TAG);
  assign timeout   = (timer_q == TIMER_LAST);
  assign pend_take = (state_q == IDLE) && pend_valid_q;
  // A done landing while the slot is being drained in IDLE refills it.
  assign pend_fill = done && ((state_q != IDLE) || pend_valid_q);

  // done takes priority over a coincident start; the start is replayed next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q         <= '0;
      run_q         <= 1'b0;
      start_defer_q <= 1'b0;
    end else begin
      start_defer_q <= (start | start_defer_q) & done;
      if (done) begin
        run_q <= 1'b0;
      end else if (start | start_defer_q) begin
        cyc_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        cyc_q <= cyc_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      line_q        <= '0;
      addr_q        <= '0;
      seq_q         <= '0;
      timer_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_status_q <= '0;
      pend_cyc_q    <= '0;
      pend_base_q   <= '0;
      c1Tx          <= '0;
      dsm_busy      <= 1'b0;
      dsm_done      <= 1'b0;
      dsm_error     <= 1'b0;
    end else begin
      c1Tx.valid <= 1'b0;
      dsm_done   <= 1'b0;

      if (pend_fill) begin
        if (pend_valid_q && !pend_take) begin
          dsm_error <= 1'b1;
        end else begin
          pend_valid_q  <= 1'b1;
          pend_status_q <= status_code;
          pend_cyc_q    <= cyc_q;
          pend_base_q   <= hc_dsm_base;
        end
      end else if (pend_take) begin
        pend_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            if (pend_base_q == '0) begin
              dsm_error <= 1'b1;
            end else begin
              addr_q   <= pend_base_q;
              line_q   <= grn_dsm_make_line(pend_cyc_q, pend_status_q, seq_q);
              dsm_busy <= 1'b1;
              state_q  <= ISSUE;
            end
          end else if (done) begin
            if (hc_dsm_base == '0) begin
              dsm_error <= 1'b1;
            end else begin
              addr_q   <= hc_dsm_base;
              line_q   <= grn_dsm_make_line(cyc_q, status_code, seq_q);
              dsm_busy <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (!c1TxAlmFull) begin
            c1Tx.valid        <= 1'b1;
            c1Tx.hdr.vc_sel   <= eVC_VA;
            c1Tx.hdr.sop      <= 1'b1;
            c1Tx.hdr.cl_len   <= eCL_LEN_1;
            c1Tx.hdr.req_type <= eREQ_WRLINE_I;
            c1Tx.hdr.address  <= addr_q;
            c1Tx.hdr.mdata    <= MDATA_TAG;
            c1Tx.data         <= line_q;
            timer_q           <= '0;
            state_q           <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (rsp_match) begin
            dsm_done <= 1'b1;
            dsm_busy <= 1'b0;
            seq_q    <= seq_q + 32'd1;
            state_q  <= IDLE;
          end else if (timeout) begin
            dsm_error <= 1'b1;
            dsm_busy  <= 1'b0;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_dsm_writer.sv
// Directed bench for grn_dsm_writer: expected DSM writes are queued when done is
// driven and compared by a monitor as each request leaves the block.
module tb_grn_dsm_writer;
  import ccip_if_pkg::*;
  import grn_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  t_hc_address    hc_dsm_base;
  logic           start;
  logic           done;
  logic [31:0]    status_code;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx c1Rx;
  t_if_ccip_c1_Tx c1Tx;
  logic           dsm_busy;
  logic           dsm_done;
  logic           dsm_error;

  always #5 clk = ~clk;

  grn_dsm_writer dut (
    .clk         (clk),
    .reset       (reset),
    .hc_dsm_base (hc_dsm_base),
    .start       (start),
    .done        (done),
    .status_code (status_code),
    .c1TxAlmFull (c1TxAlmFull),
    .c1Rx        (c1Rx),
    .c1Tx        (c1Tx),
    .dsm_busy    (dsm_busy),
    .dsm_done    (dsm_done),
    .dsm_error   (dsm_error)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] cyc;
    logic [31:0] status;
    logic [31:0] seq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   valid_cnt = 0;
  int   done_cnt  = 0;
  int   v0;
  int   d0;
  int   n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] c,
                          input logic [31:0] s, input logic [31:0] q);
    exp_t e;
    e.addr = a; e.cyc = c; e.status = s; e.seq = q;
    exp_q.push_back(e);
  endtask

  task automatic pulse_done(input logic [31:0] s);
    status_code = s;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic send_rsp(input logic [15:0] m);
    c1Rx.rspValid       = 1'b1;
    c1Rx.hdr.resp_type  = eRSP_WRLINE;
    c1Rx.hdr.mdata      = m;
    tick();
    c1Rx = '0;
  endtask

  task automatic wait_valid(input int base_cnt, input string tag);
    int k = 0;
    while (valid_cnt == base_cnt && k < 30) begin
      tick();
      k++;
    end
    chk(tag, 64'(valid_cnt), 64'(base_cnt + 1));
  endtask

  // Request monitor: every valid beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dsm_done) done_cnt++;
    if (c1Tx.valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 64'(c1Tx.valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("req addr=%0h cyc=%0d status=%0h seq=%0d", c1Tx.hdr.address,
                 c1Tx.data[127:64], c1Tx.data[159:128], c1Tx.data[191:160]);
        chk("req_addr",   64'(c1Tx.hdr.address), mon_e.addr);
        chk("req_type",   64'(c1Tx.hdr.req_type), 64'(eREQ_WRLINE_I));
        chk("req_vc",     64'(c1Tx.hdr.vc_sel), 64'(eVC_VA));
        chk("req_len",    64'(c1Tx.hdr.cl_len), 64'(eCL_LEN_1));
        chk("req_sop",    64'(c1Tx.hdr.sop), 64'd1);
        chk("req_mdata",  64'(c1Tx.hdr.mdata), 64'hD5A0);
        chk("req_flag",   c1Tx.data[63:0], 64'h1);
        chk("req_cycles", c1Tx.data[127:64], mon_e.cyc);
        chk("req_status", 64'(c1Tx.data[159:128]), 64'(mon_e.status));
        chk("req_seq",    64'(c1Tx.data[191:160]), 64'(mon_e.seq));
        chk("req_rsvd_zero", 64'(c1Tx.data[511:192] !== '0), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hc_dsm_base = '0; start = 1'b0; done = 1'b0;
    status_code = '0; c1TxAlmFull = 1'b0; c1Rx = '0;
    repeat (3) tick();
    chk("rst_tx_zero", 64'(c1Tx !== '0), 64'd0);
    chk("rst_busy",  64'(dsm_busy), 64'd0);
    chk("rst_done",  64'(dsm_done), 64'd0);
    chk("rst_error", 64'(dsm_error), 64'd0);
    reset = 1'b0;
    tick();

    // Basic write: 100 running cycles, status 5, seq 0, exact latency.
    hc_dsm_base = 42'h1000;
    start = 1'b1; tick(); start = 1'b0;
    repeat (100) tick();
    push_exp(64'h1000, 64'd100, 32'h5, 32'd0);
    pulse_done(32'h5);
    chk("basic_busy_n1", 64'(dsm_busy), 64'd1);
    chk("basic_valid_n1", 64'(c1Tx.valid), 64'd0);
    tick();
    chk("basic_valid_n2", 64'(c1Tx.valid), 64'd1);
    tick();
    chk("basic_valid_n3", 64'(c1Tx.valid), 64'd0);
    send_rsp(16'hD5A0);
    chk("basic_dsm_done", 64'(dsm_done), 64'd1);
    chk("basic_busy_fall", 64'(dsm_busy), 64'd0);
    tick();
    chk("basic_done_pulse_end", 64'(dsm_done), 64'd0);

    // Backpressure: almost-full for 20 cycles holds the request back.
    v0 = valid_cnt;
    c1TxAlmFull = 1'b1;
    push_exp(64'h1000, 64'd100, 32'h7, 32'd1);
    pulse_done(32'h7);
    repeat (20) tick();
    chk("bp_no_valid_cnt", 64'(valid_cnt), 64'(v0));
    chk("bp_busy", 64'(dsm_busy), 64'd1);
    c1TxAlmFull = 1'b0;
    tick();
    chk("bp_valid", 64'(c1Tx.valid), 64'd1);
    tick();
    chk("bp_valid_once", 64'(c1Tx.valid), 64'd0);
    repeat (3) tick();
    chk("bp_valid_cnt", 64'(valid_cnt), 64'(v0 + 1));
    send_rsp(16'hD5A0);
    chk("bp_dsm_done", 64'(dsm_done), 64'd1);

    // Unprogrammed base: error, no request, sticky until reset.
    v0 = valid_cnt;
    hc_dsm_base = '0;
    pulse_done(32'h9);
    tick();
    chk("unprog_error", 64'(dsm_error), 64'd1);
    chk("unprog_busy", 64'(dsm_busy), 64'd0);
    hc_dsm_base = 42'h1000;
    repeat (10) tick();
    chk("unprog_no_req", 64'(valid_cnt), 64'(v0));
    chk("unprog_sticky", 64'(dsm_error), 64'd1);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
    chk("unprog_cleared", 64'(dsm_error), 64'd0);

    // Pending and overflow: second done queued with its own base, third dropped.
    hc_dsm_base = 42'h2000;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    v0 = valid_cnt;
    push_exp(64'h2000, 64'd10, 32'hA, 32'd0);
    pulse_done(32'hA);
    wait_valid(v0, "pend_first_req");
    hc_dsm_base = 42'h3000;
    push_exp(64'h3000, 64'd10, 32'hB, 32'd1);
    pulse_done(32'hB);
    chk("pend_no_error", 64'(dsm_error), 64'd0);
    hc_dsm_base = 42'h4000;
    pulse_done(32'hC);
    chk("overflow_error", 64'(dsm_error), 64'd1);
    chk("pend_one_req", 64'(valid_cnt), 64'(v0 + 1));
    send_rsp(16'hD5A0);
    chk("pend_first_done", 64'(dsm_done), 64'd1);
    wait_valid(v0 + 1, "pend_second_req");
    send_rsp(16'hD5A0);
    chk("pend_second_done", 64'(dsm_done), 64'd1);
    repeat (10) tick();
    chk("pend_req_total", 64'(valid_cnt), 64'(v0 + 2));
    chk("pend_queue_empty", 64'(exp_q.size()), 64'd0);

    // Timeout with foreign mdata ignored.
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
    hc_dsm_base = 42'h1000;
    v0 = valid_cnt;
    d0 = done_cnt;
    push_exp(64'h1000, 64'd0, 32'hE, 32'd0);
    pulse_done(32'hE);
    wait_valid(v0, "to_req");
    for (int i = 0; i < 3; i++) begin
      send_rsp(16'h1234);
      chk("to_foreign_ignored", 64'(dsm_done), 64'd0);
    end
    repeat (3900) tick();
    chk("to_not_yet", 64'(dsm_error), 64'd0);
    chk("to_busy_waiting", 64'(dsm_busy), 64'd1);
    n = 0;
    while (!dsm_error && n < 400) begin
      tick();
      n++;
    end
    chk("to_error", 64'(dsm_error), 64'd1);
    chk("to_idle_busy", 64'(dsm_busy), 64'd0);
    chk("to_no_done", 64'(done_cnt), 64'(d0));
    // Sequence number must not have advanced past the timed-out write.
    v0 = valid_cnt;
    push_exp(64'h1000, 64'd0, 32'hF, 32'd0);
    pulse_done(32'hF);
    wait_valid(v0, "to_next_req");
    send_rsp(16'hD5A0);
    chk("to_next_done", 64'(dsm_done), 64'd1);
    chk("to_error_sticky", 64'(dsm_error), 64'd1);

    // Reset in WAIT_RSP: outputs clear, late response ignored.
    v0 = valid_cnt;
    push_exp(64'h1000, 64'd0, 32'h11, 32'd1);
    pulse_done(32'h11);
    wait_valid(v0, "mid_req");
    reset = 1'b1;
    tick();
    chk("mid_tx_zero", 64'(c1Tx !== '0), 64'd0);
    chk("mid_busy", 64'(dsm_busy), 64'd0);
    chk("mid_done", 64'(dsm_done), 64'd0);
    chk("mid_error", 64'(dsm_error), 64'd0);
    reset = 1'b0;
    d0 = done_cnt;
    send_rsp(16'hD5A0);
    chk("mid_late_rsp", 64'(dsm_done), 64'd0);
    repeat (3) tick();
    chk("mid_no_done", 64'(done_cnt), 64'(d0));
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grn_dsm_writer.md
# grn_dsm_writer

Host-bound status writer for the GRN accelerator: on each job-completion event it writes one 64-byte device-status-memory (DSM) line to the host address that software programmed through the CSR block. It is the AFU→host counterpart of the host→AFU CSR path. It sits between the GRN datapath and the CCI-P channel-1 (write) mux in the top level. It issues `WrLine` requests under almost-full backpressure, tracks the write response, and reports completion or error.

## Interface
- `MDATA_TAG`, 16'hD5A0: mdata value stamped on DSM writes and matched on responses.
- `RSP_TIMEOUT`, 4096: cycles to wait for the write response before flagging an error.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `hc_dsm_base`  in  t_hc_address  DSM cache-line address (byte address >> 6); 0 means unprogrammed.
- `start`  in  1  one-cycle pulse: job started; clears and enables the cycle counter.
- `done`  in  1  one-cycle pulse: job finished; triggers a DSM write.
- `status_code`  in  32  job status; sampled on the `done` cycle.
- `c1TxAlmFull`  in  1  channel-1 almost-full from the FIU.
- `c1Rx`  in  t_if_ccip_c1_Rx  write responses.
- `c1Tx`  out  t_if_ccip_c1_Tx  DSM write request, registered.
- `dsm_busy`  out  1  high from write acceptance until the response or timeout.
- `dsm_done`  out  1  one-cycle pulse when a matching write response arrives.
- `dsm_error`  out  1  sticky error; cleared only by reset.

## Operation
- **Cycle counter** (64b): cleared on `start`, increments every cycle while running, and freezes on `done`. If `start` and `done` arrive in the same cycle, `done` wins: the counter freezes at its current value, then `start` applies on the next cycle.
- **DSM line layout**:
  - [63:0] = 64'h1 (completion flag)
  - [127:64] = cycle count
  - [159:128] = `status_code`
  - [191:160] = write sequence number (32b, wraps at 2^32 to 0)
  - remaining bits 0.
- **Request header**: `req_type` = eREQ_WRLINE_I, `address` = `hc_dsm_base` latched on the `done` cycle, `vc_sel` = eVC_VA, `cl_len` = eCL_LEN_1, `sop` = 1, `mdata` = `MDATA_TAG`.
- **FSM states**:
  - IDLE: on `done`, if `hc_dsm_base` == 0, set `dsm_error` and stay in IDLE; otherwise latch the payload and go to ISSUE.
  - ISSUE: when `c1TxAlmFull` == 0, drive `c1Tx.valid` for exactly one cycle and go to WAIT_RSP. Stay in ISSUE while almost-full is high.
  - WAIT_RSP: a match is `c1Rx.rspValid` with `hdr.resp_type` == eRSP_WRLINE and `hdr.mdata` == `MDATA_TAG`. On a match, pulse `dsm_done`, increment the sequence number, and go to IDLE. Responses with any other mdata are ignored.
  - Timeout: after `RSP_TIMEOUT` cycles in WAIT_RSP, set `dsm_error` and go to IDLE; the sequence number is not incremented.
- **`done` while not in IDLE**: a one-deep pending slot latches `status_code`, the cycle count and `hc_dsm_base`. The pending write is issued on the cycle after the FSM returns to IDLE. A further `done` while the slot is full is dropped and sets `dsm_error`.
- **Reset mid-operation**: abandons any outstanding write with no retry. A late response arriving after reset is ignored (the FSM is in IDLE).

## Timing
- **Reset values**: `c1Tx` all zero (`valid` = 0), `dsm_busy` = 0, `dsm_done` = 0, `dsm_error` = 0, cycle counter = 0, sequence number = 0, pending slot empty.
- **Latency**: `done` at cycle N with almost-full low → `c1Tx.valid` at N+2 (one cycle latch, one cycle output register).
- `dsm_busy` rises at N+1 and falls the cycle after the matching response or the timeout.
- `dsm_done` is asserted the cycle after the matching `c1Rx` beat.
- **Backpressure**: `c1TxAlmFull` is sampled in ISSUE. Once `c1Tx.valid` is asserted, the request is never withdrawn or repeated.

## Structure
- The following go in `grn_pkg`:
  - `t_grn_dsm_line` (packed 512b struct matching the layout above)
  - `t_grn_dsm_state` enum (IDLE, ISSUE, WAIT_RSP)
  - `GRN_DSM_MDATA` constant
  - `GRN_DSM_FLAG` constant
- CCI-P types come from `ccip_if_pkg`.
- Single module; no sub-module is warranted.

## Test plan
- **Basic write**: `hc_dsm_base` = 'h1000, `start`, 100 cycles, `done` with `status_code` = 'h5 → one WrLine to 'h1000 with [127:64] = 100, [159:128] = 5, seq = 0. Response with mdata 'hD5A0 → `dsm_done` pulse.
- **Backpressure**: `c1TxAlmFull` held high for 20 cycles after `done` → no `valid` until almost-full drops, then exactly one `valid` cycle.
- **Unprogrammed base**: `hc_dsm_base` = 0 at `done` → no request, `dsm_error` = 1 and it persists until reset.
- **Pending and overflow**: three `done` pulses while WAIT_RSP → second issued after the first response with seq = 1; third dropped and `dsm_error` = 1.
- **Timeout and mdata filtering**: responses with mdata 'h1234 only → ignored. After 4096 cycles → `dsm_error`, FSM in IDLE, seq unchanged.
- **Reset mid-operation**: reset asserted in WAIT_RSP → all outputs zero next cycle. A late response afterwards produces no `dsm_done`.
